// File: rtl/xdma_h2c_pkg.sv
// rtl/xdma_h2c_pkg.sv - opcode constants and FSM state encoding for the H2C step controller
package xdma_h2c_pkg;

    localparam logic [7:0] OP_STEP       = 8'h01;
    localparam logic [7:0] OP_RUN        = 8'h02;
    localparam logic [7:0] OP_HALT       = 8'h03;
    localparam logic [7:0] OP_CORE_RESET = 8'h04;

    localparam logic [15:0] BAD_CMD_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_CRST = 2'd3
    } state_t;

endpackage

// File: rtl/xdma_h2c_step_ctrl.sv
// rtl/xdma_h2c_step_ctrl.sv - host-driven core clock gating: single-step, free-run, halt and core reset
module xdma_h2c_step_ctrl
    import xdma_h2c_pkg::*;
#(
    parameter int STEP_W = 32,
    parameter int CNT_W  = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             xdma_axis_valid,
    input  logic [511:0]     xdma_axis_data,
    output logic             xdma_axis_ready,
    input  logic             stall_in,
    output logic             core_clock_enable,
    output logic             core_reset,
    output logic             busy,
    output logic [CNT_W-1:0] cycles_done,
    output logic [15:0]      bad_cmd_count
);

    state_t            state, state_next;
    logic [STEP_W-1:0] remaining, remaining_next;
    logic [7:0]        crst_left, crst_left_next;
    logic              fire;
    logic              bad_op;
    logic [7:0]        opcode;
    logic [7:0]        crst_len;
    logic [STEP_W-1:0] step_n;
    logic              unused_data;

    assign opcode      = xdma_axis_data[7:0];
    assign crst_len    = xdma_axis_data[15:8];
    assign step_n      = xdma_axis_data[STEP_W+31:32];
    assign unused_data = ^{xdma_axis_data[511:STEP_W+32], xdma_axis_data[31:16]};

    assign xdma_axis_ready   = (state == ST_IDLE) || (state == ST_RUN);
    assign fire              = xdma_axis_valid && xdma_axis_ready;
    assign core_clock_enable = ((state == ST_STEP) || (state == ST_RUN)) && !stall_in;
    assign core_reset        = (state == ST_CRST);
    assign busy              = (state != ST_IDLE);

    // Commands only fire in IDLE/RUN, so they never collide with the STEP/CRST countdowns.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        crst_left_next = crst_left;
        bad_op         = 1'b0;
        case (state)
            ST_STEP: begin
                if (core_clock_enable) begin
                    remaining_next = remaining - STEP_W'(1);
                    if (remaining == STEP_W'(1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_CRST: begin
                if (crst_left == 8'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    crst_left_next = crst_left - 8'd1;
                end
            end
            default: ;
        endcase
        if (fire) begin
            case (opcode)
                OP_STEP: begin
                    if (step_n != '0) begin
                        remaining_next = step_n;
                        state_next     = ST_STEP;
                    end
                end
                OP_RUN:  state_next = ST_RUN;
                OP_HALT: state_next = ST_IDLE;
                OP_CORE_RESET: begin
                    crst_left_next = crst_len;
                    state_next     = ST_CRST;
                end
                default: bad_op = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            crst_left     <= '0;
            cycles_done   <= '0;
            bad_cmd_count <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            crst_left <= crst_left_next;
            if (core_clock_enable) begin
                cycles_done <= cycles_done + CNT_W'(1);
            end
            if (bad_op && (bad_cmd_count != BAD_CMD_MAX)) begin
                bad_cmd_count <= bad_cmd_count + 16'd1;
            end
        end
    end

endmodule
